// File: rtl/ws2812_pkg.sv
// Shared types and default timing for the WS2812 frame driver.
// Timing defaults assume a 50 MHz clock.
package ws2812_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    SEND,
    NEXT,
    LATCH
  } state_t;

  localparam int DEF_NUM_PIXELS = 128;
  localparam int DEF_T0H_CYC    = 20;
  localparam int DEF_T1H_CYC    = 40;
  localparam int DEF_TBIT_CYC   = 63;
  localparam int DEF_TLATCH_CYC = 14000;

  localparam int PIXEL_W = 7;
  localparam int COLOR_W = 24;

endpackage

// File: rtl/ws2812_bit_timer.sv
// WS2812 bit waveform generator; owns the cycle counter that the
// frame FSM also reuses for latch timing.
module ws2812_bit_timer #(
  parameter int CYC_W    = 14,
  parameter int T0H_CYC  = 20,
  parameter int T1H_CYC  = 40,
  parameter int TBIT_CYC = 63
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             count,
  input  logic             send,
  input  logic             bit_val,
  output logic [CYC_W-1:0] cnt,
  output logic             bit_end,
  output logic             dout
);

  localparam logic [CYC_W-1:0] T0H  = CYC_W'(T0H_CYC);
  localparam logic [CYC_W-1:0] T1H  = CYC_W'(T1H_CYC);
  localparam logic [CYC_W-1:0] TEND = CYC_W'(TBIT_CYC - 1);

  logic [CYC_W-1:0] high_len;

  assign high_len = bit_val ? T1H : T0H;
  assign bit_end  = send && (cnt == TEND);

  // Outside SEND the counter runs free so it can time the latch.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      cnt <= '0;
    end else if (count) begin
      cnt <= bit_end ? '0 : cnt + CYC_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      dout <= 1'b0;
    end else begin
      dout <= send && (cnt < high_len);
    end
  end

endmodule

// File: rtl/ws2812_frame_driver.sv
// WS2812 frame driver: walks pixels, serialises GRB words, then latches.
// Build option WS2812_AUTO_REFRESH_EN streams frames back to back.
module ws2812_frame_driver
  import ws2812_pkg::*;
#(
  parameter int NUM_PIXELS = DEF_NUM_PIXELS,
  parameter int T0H_CYC    = DEF_T0H_CYC,
  parameter int T1H_CYC    = DEF_T1H_CYC,
  parameter int TBIT_CYC   = DEF_TBIT_CYC,
  parameter int TLATCH_CYC = DEF_TLATCH_CYC
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [COLOR_W-1:0] color_in,
  output logic [PIXEL_W-1:0] pixel_index,
  output logic               dout,
  output logic               busy,
  output logic               frame_done
);

  localparam int CYC_W = $clog2(TLATCH_CYC);
  localparam logic [PIXEL_W-1:0] LAST_PIX =
    PIXEL_W'(NUM_PIXELS - 1);
  localparam logic [CYC_W-1:0] LATCH_END =
    CYC_W'(TLATCH_CYC - 1);

  state_t             state;
  state_t             state_n;
  logic [PIXEL_W-1:0] pix_n;
  logic               busy_n;
  logic               done_n;
  logic [COLOR_W-1:0] shreg;
  logic [COLOR_W-1:0] shreg_n;
  logic [4:0]         bit_cnt;
  logic [4:0]         bit_cnt_n;
  logic [CYC_W-1:0]   cyc_cnt;
  logic               bit_end;
  logic               t_clear;
  logic               t_count;
  logic               t_send;

  assign t_clear = state inside {IDLE, LOAD, NEXT};
  assign t_count = state inside {SEND, LATCH};
  assign t_send  = (state == SEND);

  ws2812_bit_timer #(
    .CYC_W    (CYC_W),
    .T0H_CYC  (T0H_CYC),
    .T1H_CYC  (T1H_CYC),
    .TBIT_CYC (TBIT_CYC)
  ) u_timer (
    .clk     (clk),
    .reset   (reset),
    .clear   (t_clear),
    .count   (t_count),
    .send    (t_send),
    .bit_val (shreg[COLOR_W-1]),
    .cnt     (cyc_cnt),
    .bit_end (bit_end),
    .dout    (dout)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      pixel_index <= '0;
      busy        <= 1'b0;
      frame_done  <= 1'b0;
      shreg       <= '0;
      bit_cnt     <= '0;
    end else begin
      state       <= state_n;
      pixel_index <= pix_n;
      busy        <= busy_n;
      frame_done  <= done_n;
      shreg       <= shreg_n;
      bit_cnt     <= bit_cnt_n;
    end
  end

`ifdef WS2812_AUTO_REFRESH_EN
  logic unused_start;
  assign unused_start = start;
`endif

  always_comb begin
    state_n   = state;
    pix_n     = pixel_index;
    busy_n    = busy;
    done_n    = 1'b0;
    shreg_n   = shreg;
    bit_cnt_n = bit_cnt;
    unique case (state)
      IDLE: begin
        pix_n = '0;
`ifdef WS2812_AUTO_REFRESH_EN
        state_n = LOAD;
        busy_n  = 1'b1;
`else
        if (start) begin
          state_n = LOAD;
          busy_n  = 1'b1;
        end
`endif
      end
      LOAD: begin
        shreg_n   = color_in;
        bit_cnt_n = 5'd23;
        state_n   = SEND;
      end
      SEND: begin
        if (bit_end) begin
          if (bit_cnt != 5'd0) begin
            shreg_n   = {shreg[COLOR_W-2:0], 1'b0};
            bit_cnt_n = bit_cnt - 5'd1;
          end else begin
            state_n = NEXT;
          end
        end
      end
      NEXT: begin
        if (pixel_index == LAST_PIX) begin
          state_n = LATCH;
        end else begin
          pix_n   = pixel_index + PIXEL_W'(1);
          state_n = LOAD;
        end
      end
      LATCH: begin
        if (cyc_cnt == LATCH_END) begin
          done_n = 1'b1;
          pix_n  = '0;
`ifdef WS2812_AUTO_REFRESH_EN
          state_n = LOAD;
`else
          state_n = IDLE;
          busy_n  = 1'b0;
`endif
        end
      end
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_ws2812_frame_driver.sv
// Self-checking bench for ws2812_frame_driver with shortened bit timing.
// Frame model is a pure function of cycles since the accepted start.
module tb_ws2812_frame_driver;

  localparam int NP       = 128;
  localparam int T0H      = 2;
  localparam int T1H      = 3;
  localparam int TBIT     = 5;
  localparam int TLATCH   = 20;
  localparam int PIX_CYC  = 24 * TBIT + 2;
  localparam int FRAME_CYC = NP * PIX_CYC + TLATCH + 1;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [23:0] color_in;
  logic [6:0]  pixel_index;
  logic        dout;
  logic        busy;
  logic        frame_done;

  always #5 clk = ~clk;

  ws2812_frame_driver #(
    .NUM_PIXELS (NP),
    .T0H_CYC    (T0H),
    .T1H_CYC    (T1H),
    .TBIT_CYC   (TBIT),
    .TLATCH_CYC (TLATCH)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .color_in    (color_in),
    .pixel_index (pixel_index),
    .dout        (dout),
    .busy        (busy),
    .frame_done  (frame_done)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  always @(posedge clk) cyc++;

  // Upstream comparator model
  int          mode = 0;
  logic [23:0] ctab [NP];
  logic [23:0] noise = '0;
  logic [23:0] base;
  bit          noise_en = 0;

  always_comb begin
    base = '0;
    case (mode)
      0: base = 24'h00ff00;
      1: base = (pixel_index == 7'd64) ? 24'hffff00 : 24'h0;
      default: base = ctab[pixel_index];
    endcase
    color_in = base ^ noise;
  end

  function automatic logic [23:0] cmp(input int p);
    case (mode)
      0: return 24'h00ff00;
      1: return (p == 64) ? 24'hffff00 : 24'h0;
      default: return ctab[p];
    endcase
  endfunction

  // Frame model: mn = cycles since the edge that accepted start
  bit          mact = 0;
  int          mn = 0;
  logic [23:0] mcol [NP];

  always @(posedge clk) begin
    int u;
    u = mn - 1;
    if (reset) begin
      mact = 0;
    end else if (mact && mn < FRAME_CYC) begin
      if (u < NP * PIX_CYC && (u % PIX_CYC) == 0)
        mcol[u / PIX_CYC] = cmp(u / PIX_CYC) ^ noise;
      mn++;
    end else if (start) begin
      mact = 1;
      mn   = 1;
    end else begin
      mact = 0;
    end
  end

  function automatic logic [9:0] expv();
    int u, p, r, s;
    logic b, d;
    if (!mact) return 10'd0;
    if (mn == FRAME_CYC) return {1'b0, 1'b0, 1'b1, 7'd0};
    u = mn - 1;
    if (u >= NP * PIX_CYC) return {1'b0, 1'b1, 1'b0, 7'(NP - 1)};
    p = u / PIX_CYC;
    r = u % PIX_CYC;
    d = 1'b0;
    if (r >= 2 && r - 2 < 24 * TBIT) begin
      s = r - 2;
      b = mcol[p][23 - s / TBIT];
      d = (s % TBIT) < (b ? T1H : T0H);
    end
    return {d, 1'b1, 1'b0, 7'(p)};
  endfunction

  always @(negedge clk) begin
    logic [9:0] e, a;
    if (cyc > 0) begin
      e = expv();
      a = {dout, busy, frame_done, pixel_index};
      checks++;
      if (a !== e) begin
        errors++;
        $display("FAIL out@%0d act=%h exp=%h", cyc, a, e);
      end
    end
  end

  // Decoder: high-pulse widths seen on dout
  int widths[$];
  int run = 0;

  always @(negedge clk) begin
    if (reset) begin
      run = 0;
    end else if (dout) begin
      run++;
    end else if (run > 0) begin
      widths.push_back(run);
      run = 0;
    end
  end

  function automatic logic [23:0] word(input int i);
    logic [23:0] w;
    w = '0;
    for (int j = 0; j < 24; j++)
      if (i * 24 + j < widths.size())
        w[23 - j] = (widths[i * 24 + j] == T1H);
    return w;
  endfunction

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic chk(input string nm, input logic [31:0] a,
                     input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h", nm, a, e);
    end
  endtask

  task automatic do_start(output int t0);
    start = 1'b1;
    t0 = cyc;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_n(input int target, input string nm);
    bit ok;
    ok = 0;
    for (int k = 0; k < FRAME_CYC + 50; k++) begin
      if (mact && mn == target) begin
        ok = 1;
        break;
      end
      if (noise_en && $urandom_range(0, 19) == 0)
        noise = 24'($urandom);
      tick();
    end
    chk(nm, 32'(ok), 32'd1);
  endtask

  task automatic wait_done(input int t0, output int dt);
    bit ok;
    ok = 0;
    dt = 0;
    for (int k = 0; k < FRAME_CYC + 50; k++) begin
      tick();
      if (frame_done) begin
        ok = 1;
        dt = cyc - t0;
        break;
      end
    end
    chk("done_seen", 32'(ok), 32'd1);
  endtask

  initial begin
    int t0, dt, nz;
    for (int i = 0; i < NP; i++) ctab[i] = 24'($urandom);

    reset = 1'b1;
    repeat (3) tick();
    reset = 1'b0;
    tick();
    chk("rst_idle", {dout, busy, frame_done, pixel_index}, 0);

    // Frame 1: fixed colour, start re-pulsed mid-frame and at latch end
    mode = 0;
    widths.delete();
    do_start(t0);
    wait_n(10 * PIX_CYC + 40, "f1_pix10");
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_n(FRAME_CYC - 1, "f1_latch_end");
    chk("f1_pix_last", pixel_index, 7'd127);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("f1_done", frame_done, 1);
    chk("f1_len", cyc - t0, NP * 1 * (24 * 5 + 2) + 20 + 1);
    repeat (5) tick();
    chk("f1_no_restart", busy, 0);
    chk("f1_nbits", widths.size(), 3072);
    for (int j = 0; j < 24; j++)
      chk($sformatf("f1_w%0d", j), widths[j],
          (j >= 8 && j < 16) ? 3 : 2);

    // Frame 2: single lit pixel at index 64
    mode = 1;
    widths.delete();
    do_start(t0);
    wait_done(t0, dt);
    chk("f2_len", dt, FRAME_CYC);
    chk("f2_nbits", widths.size(), NP * 24);
    nz = 0;
    for (int i = 0; i < NP; i++)
      if (word(i) != 24'h0) nz++;
    chk("f2_word64", word(64), 24'hffff00);
    chk("f2_nonzero", nz, 1);
    repeat (3) tick();

    // Frame 3: random colours with upstream churn, reset at pixel 50 bit 7
    mode = 2;
    noise_en = 1;
    do_start(t0);
    wait_n(50 * PIX_CYC + 2 + 7 * TBIT + 2, "f3_pix50");
    noise_en = 0;
    reset = 1'b1;
    tick();
    chk("rst_mid", {dout, busy, pixel_index}, 0);
    reset = 1'b0;
    noise = '0;
    repeat (TLATCH + 2) tick();

    // Frame 4: colour changes while pixel 5 is shifting
    for (int i = 0; i < NP; i++) ctab[i] = 24'($urandom);
    widths.delete();
    do_start(t0);
    wait_n(5 * PIX_CYC + 12, "f4_mid5");
    noise = 24'h5a5a5a;
    wait_n(5 * PIX_CYC + 100, "f4_end5");
    noise = '0;
    wait_done(t0, dt);
    chk("f4_len", dt, FRAME_CYC);
    chk("f4_word0", word(0), ctab[0]);
    chk("f4_word5", word(5), ctab[5]);
    chk("f4_word127", word(127), ctab[127]);
    repeat (3) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
